// File: rtl/io_pkg.sv
// Shared definitions for the I/O port responder slice.
//   out_state_e : output FSM encoding (StIdle = 0, StHold = 1)
//   DefDataW    : default byte width
//   DefDepth    : default output FIFO depth
//   EmptyRead   : value returned by an IN read when nothing is held
package io_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } out_state_e;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 4;

  localparam logic [7:0] EmptyRead = 8'h00;

endpackage

// File: rtl/io_port_responder_if.sv
// Bus bundle between the CPU/board side and io_port_responder.
//   CPU strobes : io_enable, io_write_enable, io_wdata, io_rdata
//   Out stream  : out_data, out_valid, out_ready
//   In capture  : in_data, in_valid, in_ready
//   Status      : fifo_full, ovf_flag, ovf_clr
//   tx_count    : present only when IO_TXCOUNT_EN is defined
// master = CPU/board side, slave = the responder.
interface io_port_responder_if #(
  parameter int unsigned DATA_W = 8
);
  logic              io_enable;
  logic              io_write_enable;
  logic [DATA_W-1:0] io_wdata;
  logic [DATA_W-1:0] io_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              fifo_full;
  logic              ovf_flag;
  logic              ovf_clr;
`ifdef IO_TXCOUNT_EN
  logic [7:0]        tx_count;
`endif

  modport master (
    output io_enable, io_write_enable, io_wdata, out_ready, in_data, in_valid, ovf_clr,
    input
`ifdef IO_TXCOUNT_EN
           tx_count,
`endif
           io_rdata, out_data, out_valid, in_ready, fifo_full, ovf_flag
  );

  modport slave (
    input  io_enable, io_write_enable, io_wdata, out_ready, in_data, in_valid, ovf_clr,
    output
`ifdef IO_TXCOUNT_EN
           tx_count,
`endif
           io_rdata, out_data, out_valid, in_ready, fifo_full, ovf_flag
  );
endinterface

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with simultaneous push/pop.
//   clk, reset_n : clock, async active-low reset
//   push, wdata  : write request and data; accepted when not full or when popping
//   pop          : remove head (ignored when empty)
//   head         : current head entry
//   full, empty  : occupancy flags
module io_sync_fifo import io_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot this edge, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/io_port_responder.sv
// Peripheral responder for CPU IN/OUT strobes.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : OUT writes are queued in io_sync_fifo and streamed on
//                  out_data/out_valid/out_ready; IN reads return the byte held
//                  from in_data/in_valid (or 8'h00 when empty) on io_rdata.
//                  ovf_flag is sticky on a dropped write, cleared by ovf_clr.
// Optional: define IO_TXCOUNT_EN to add tx_count, a wrapping count of out handshakes.
module io_port_responder import io_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 reset_n,
  io_port_responder_if.slave  bus
);

  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ovf_q;

  logic              push, rd, pop, drop, out_valid;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign push = bus.io_enable & bus.io_write_enable;
  assign rd   = bus.io_enable & ~bus.io_write_enable;
  assign drop = push & fifo_full & ~pop;

  io_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (bus.io_wdata),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Output FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
    end
  end

  // Output FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StHold;
      StHold:  if (bus.out_ready && fifo_empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output FSM: outputs (pop strobe and next presented byte)
  always_comb begin
    pop        = 1'b0;
    out_data_d = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          out_data_d = fifo_head;
        end
      end
      StHold: begin
        if (bus.out_ready && !fifo_empty) begin
          pop        = 1'b1;
          out_data_d = fifo_head;
        end
      end
      default: ;
    endcase
  end

  // out_valid derives from state so reset clears it asynchronously
  assign out_valid = (state_q == StHold);

  // Read path: a read frees the register, but a capture only happens if it
  // was empty before the edge, so a same-cycle offer is not taken while full.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rdata_d     = rdata_q;
    if (rd) begin
      rdata_d     = hold_full_q ? hold_q : DATA_W'(EmptyRead);
      hold_full_d = 1'b0;
    end
    if (bus.in_valid && !hold_full_q) begin
      hold_d      = bus.in_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rdata_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rdata_q     <= rdata_d;
      if (bus.ovf_clr)   ovf_q <= 1'b0;
      else if (drop)     ovf_q <= 1'b1;
    end
  end

`ifdef IO_TXCOUNT_EN
  logic [7:0] tx_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_count_q <= 8'd0;
    end else if (out_valid && bus.out_ready) begin
      tx_count_q <= tx_count_q + 8'd1;
    end
  end

  assign bus.tx_count = tx_count_q;
`endif

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.io_rdata  = rdata_q;
  assign bus.in_ready  = ~hold_full_q;
  assign bus.fifo_full = fifo_full;
  assign bus.ovf_flag  = ovf_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: directed vectors, a queue-based reference
// model checked every cycle, plus literal expectations along the way.
module tb_io_port_responder;

  localparam int unsigned DataW = 8;
  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  bit   cmp_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  io_port_responder_if #(.DATA_W(DataW)) bus ();

  io_port_responder #(
    .DATA_W (DataW),
    .DEPTH  (Depth),
    .PTR_W  (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted byte not yet handed off, in order.
  // m_shown says whether the front byte is currently presented.
  logic [7:0] m_pend[$];
  bit         m_shown = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_hfull = 1'b0;
  logic [7:0] m_hdata = 8'h00;
  logic [7:0] m_rdata = 8'h00;
  int         m_tx = 0;
  int         m_waiting;
  bit         m_hs, m_pop, m_wr, m_rd, m_acc, m_cap;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend.delete();
      m_shown = 1'b0;
      m_ovf   = 1'b0;
      m_hfull = 1'b0;
      m_hdata = 8'h00;
      m_rdata = 8'h00;
      m_tx    = 0;
    end else begin
      m_waiting = m_pend.size() - int'(m_shown);
      m_hs  = m_shown && bus.out_ready;
      m_pop = (m_waiting > 0) && (!m_shown || bus.out_ready);
      m_wr  = bus.io_enable && bus.io_write_enable;
      m_rd  = bus.io_enable && !bus.io_write_enable;
      m_acc = m_wr && ((m_waiting < int'(Depth)) || m_pop);
      if (m_hs) begin
        void'(m_pend.pop_front());
        m_tx = (m_tx + 1) % 256;
      end
      if (m_pop) m_shown = 1'b1;
      else if (m_hs) m_shown = 1'b0;
      if (m_acc) m_pend.push_back(bus.io_wdata);
      if (bus.ovf_clr) m_ovf = 1'b0;
      else if (m_wr && !m_acc) m_ovf = 1'b1;
      m_cap = bus.in_valid && !m_hfull;
      if (m_rd) begin
        m_rdata = m_hfull ? m_hdata : 8'h00;
        m_hfull = 1'b0;
      end
      if (m_cap) begin
        m_hdata = bus.in_data;
        m_hfull = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_out_valid", 32'(bus.out_valid), 32'(m_shown));
      if (m_shown && m_pend.size() > 0) chk("cmp_out_data", 32'(bus.out_data), 32'(m_pend[0]));
      chk("cmp_fifo_full", 32'(bus.fifo_full),
          32'((m_pend.size() - int'(m_shown)) == int'(Depth)));
      chk("cmp_ovf_flag", 32'(bus.ovf_flag), 32'(m_ovf));
      chk("cmp_in_ready", 32'(bus.in_ready), 32'(!m_hfull));
      chk("cmp_io_rdata", 32'(bus.io_rdata), 32'(m_rdata));
`ifdef IO_TXCOUNT_EN
      chk("cmp_tx_count", 32'(bus.tx_count), 32'(m_tx));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.io_enable       = 1'b1;
    bus.io_write_enable = 1'b1;
    bus.io_wdata        = d;
    tick();
    bus.io_enable       = 1'b0;
    bus.io_write_enable = 1'b0;
  endtask

  task automatic rd();
    bus.io_enable       = 1'b1;
    bus.io_write_enable = 1'b0;
    tick();
    bus.io_enable       = 1'b0;
  endtask

  logic [7:0] exp3 [5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h77};

  initial begin
    bus.io_enable       = 1'b0;
    bus.io_write_enable = 1'b0;
    bus.io_wdata        = 8'h00;
    bus.out_ready       = 1'b0;
    bus.in_data         = 8'h00;
    bus.in_valid        = 1'b0;
    bus.ovf_clr         = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    cmp_en = 1'b1;

    // Reset state
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_ovf", 32'(bus.ovf_flag), 32'd0);
    chk("rst_rdata", 32'(bus.io_rdata), 32'h00);
    chk("rst_full", 32'(bus.fifo_full), 32'd0);

    // Single byte pass-through
    bus.out_ready = 1'b1;
    wr(8'hA5);
    chk("t1_valid_push_edge", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_data", 32'(bus.out_data), 32'hA5);
    tick();
    chk("t1_valid_drop", 32'(bus.out_valid), 32'd0);

    // Fill, overflow, drain
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) wr(8'(i));
    chk("t2_data_held", 32'(bus.out_data), 32'h01);
    chk("t2_full", 32'(bus.fifo_full), 32'd1);
    chk("t2_no_ovf", 32'(bus.ovf_flag), 32'd0);
    wr(8'h06);
    chk("t2_ovf", 32'(bus.ovf_flag), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("t2_drain_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_drain_data", 32'(bus.out_data), 32'(i));
      tick();
    end
    chk("t2_drained", 32'(bus.out_valid), 32'd0);
    chk("t2_ovf_sticky", 32'(bus.ovf_flag), 32'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t2_ovf_clr", 32'(bus.ovf_flag), 32'd0);

    // Full FIFO: clear beats set, then push+pop while full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
    chk("t3_full", 32'(bus.fifo_full), 32'd1);
    bus.ovf_clr = 1'b1;
    wr(8'h99);
    bus.ovf_clr = 1'b0;
    chk("t3_clr_priority", 32'(bus.ovf_flag), 32'd0);
    bus.out_ready = 1'b1;
    chk("t3_head", 32'(bus.out_data), 32'h10);
    wr(8'h77);
    for (int i = 0; i < 5; i++) begin
      chk("t3_seq_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_seq_data", 32'(bus.out_data), 32'(exp3[i]));
      tick();
    end
    chk("t3_done", 32'(bus.out_valid), 32'd0);
    chk("t3_no_ovf", 32'(bus.ovf_flag), 32'd0);

    // IN capture and reads
    bus.in_data  = 8'h3C;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
    rd();
    chk("t4_rdata", 32'(bus.io_rdata), 32'h3C);
    chk("t4_in_ready_high", 32'(bus.in_ready), 32'd1);
    rd();
    chk("t4_rdata_empty", 32'(bus.io_rdata), 32'h00);

    // Read and offer in the same cycle while full
    bus.in_data  = 8'h11;
    bus.in_valid = 1'b1;
    tick();
    chk("t5_held", 32'(bus.in_ready), 32'd0);
    bus.in_data         = 8'h22;
    bus.io_enable       = 1'b1;
    bus.io_write_enable = 1'b0;
    tick();
    bus.io_enable = 1'b0;
    bus.in_valid  = 1'b0;
    chk("t5_rdata_old", 32'(bus.io_rdata), 32'h11);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
    rd();
    chk("t5_not_captured", 32'(bus.io_rdata), 32'h00);

    // Reset mid-operation
    bus.out_ready = 1'b0;
    wr(8'h41);
    wr(8'h42);
    wr(8'h43);
    chk("t6_valid_before", 32'(bus.out_valid), 32'd1);
    chk("t6_data_before", 32'(bus.out_data), 32'h41);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_async_full", 32'(bus.fifo_full), 32'd0);
`ifdef IO_TXCOUNT_EN
    chk("t6_tx_reset", 32'(bus.tx_count), 32'd0);
`endif
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    wr(8'h55);
    chk("t6_not_yet", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t6_new_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_new_data", 32'(bus.out_data), 32'h55);
    tick();
    chk("t6_only_new", 32'(bus.out_valid), 32'd0);

`ifdef IO_TXCOUNT_EN
    chk("t7_tx_one", 32'(bus.tx_count), 32'd1);
    for (int i = 0; i < 255; i++) wr(8'(i));
    tick();
    tick();
    chk("t7_tx_wrap", 32'(bus.tx_count), 32'd0);
    wr(8'hEE);
    tick();
    tick();
    chk("t7_tx_after_wrap", 32'(bus.tx_count), 32'd1);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Peripheral-side responder for the CPU's I/O strobes (io_enable, io_write_enable).
- On an OUT write, the byte is buffered in a small FIFO and presented to an external device with a valid/ready handshake.
- On an IN read, it returns a byte captured from an external source through a one-entry holding register.
- Sits between the 8-bit CPU core and board-level I/O (LEDs, UART TX wrapper, switches).

Parameters:
- DATA_W, 8, data width of CPU and device bytes.
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- io_enable  in  1  CPU I/O access strobe, one cycle per access.
- io_write_enable  in  1  1 = OUT write, 0 = IN read; sampled only when io_enable=1.
- io_wdata  in  DATA_W  CPU write byte.
- io_rdata  out  DATA_W  read byte returned to the CPU.
- out_data  out  DATA_W  byte presented to the external device.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  external device accepts out_data.
- in_data  in  DATA_W  external input byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  holding register is empty.
- fifo_full  out  1  output FIFO is full.
- ovf_flag  out  1  sticky flag: a write was dropped.
- ovf_clr  in  1  synchronous clear of ovf_flag.

Behaviour:
- Reset (reset_n=0, asynchronous): FIFO pointers and count = 0, out_valid=0, out_data=0, io_rdata=0, in_ready=1, ovf_flag=0, output FSM = IDLE.

Write path:
- When io_enable & io_write_enable, push io_wdata.
- If the FIFO is full and no pop occurs in the same cycle, drop the byte and set ovf_flag.
- If a push and pop coincide, both occur and count is unchanged; the push is accepted even when full.

Output FSM (IDLE, HOLD):
- IDLE: if FIFO is non-empty, load the head into out_data, pop, set out_valid=1, go to HOLD. Latency is one cycle from the push edge to out_valid.
- HOLD: out_data stays stable while out_valid=1 and out_ready=0.
- HOLD with out_ready=1 and FIFO non-empty: load the next byte and pop in the same cycle, stay in HOLD (back-to-back, one byte per cycle).
- HOLD with out_ready=1 and FIFO empty: clear out_valid, go to IDLE.
- out_ready is ignored in IDLE.

Pointers and count:
- Pointers are PTR_W bits and wrap modulo DEPTH.
- Count is PTR_W+1 bits.
- fifo_full = (count == DEPTH).

Read path:
- Holding register captures in_data when in_valid & in_ready; in_ready then goes to 0.
- io_enable & ~io_write_enable registers io_rdata on the next edge:
  - holding register full: returns the held byte and frees the register (in_ready=1 after that edge).
  - holding register empty: returns 8'h00.
- io_rdata holds its value until the next read.
- Read and capture in the same cycle: the read returns the old content, and the new byte is captured only if the register was empty before the edge.

ovf_flag:
- ovf_clr has priority over a set in the same cycle.

Reset mid-operation:
- Any in-flight FIFO contents and the held input byte are discarded.
- out_valid drops immediately (asynchronous).

Optional Feature:
- Macro IO_TXCOUNT_EN.
- Defined: adds output port tx_count [7:0]. It increments on each completed out handshake (out_valid & out_ready), wraps 255 to 0, and resets to 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package io_pkg holds:
  - output FSM state encoding (IDLE=1'b0, HOLD=1'b1)
  - default DATA_W and DEPTH constants
  - the 8'h00 empty-read value
- Sub-module io_sync_fifo (DATA_W, DEPTH) provides push/pop/full/empty/head with simultaneous push+pop support.
- The responder instantiates it and implements the output FSM, read holding register and flags.

Test Plan:
- Reset, then write 0xA5 with out_ready=1 -> out_valid rises the cycle after the write, out_data=0xA5 for 1 cycle, then out_valid=0.
- Writes 0x01,0x02,0x03,0x04,0x05 on consecutive cycles with out_ready=0 -> 0x01 held in out_data, FIFO holds 0x02-0x05, fifo_full=1, no drop. A sixth write 0x06 -> dropped, ovf_flag=1. Raise out_ready -> 0x01..0x05 emitted on consecutive cycles. ovf_clr -> ovf_flag=0.
- With the FIFO full, out_ready=1 and a write 0x77 in the same cycle -> 0x77 accepted and emitted last, ovf_flag stays 0.
- in_data=0x3C, in_valid=1 -> in_ready=0. Read -> io_rdata=0x3C next cycle, in_ready=1. Second read -> io_rdata=0x00.
- Read in the same cycle as in_valid with 0x11 held and 0x22 offered -> io_rdata=0x11, 0x22 not captured, in_ready=1.
- reset_n pulsed low while out_valid=1 with 2 bytes queued -> out_valid=0 immediately, FIFO empty, and the next write emits only the new byte. With IO_TXCOUNT_EN defined, tx_count returns to 0 and 256 handshakes wrap it to 0.
